instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The module SHALL have parameter IMEM_DEPTH, default 64, meaning the number of 32-bit instruction memory words, indexed by pc[7:2].
REQ-002 The module SHALL have parameter ISSUE_GAP, default 8, meaning the number of WAIT cycles after each issue, legal range 1..255.
REQ-003 The module SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, meaning the instruction encoding that stops fetching.
REQ-004 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port run, input, 1 bit: enables fetching.
REQ-007 The module SHALL have ports load_en (input, 1), load_addr (input, 6) and load_data (input, 32): the instruction memory write port.
REQ-008 The module SHALL have port br_zero, input, 1 bit: the datapath equality flag for beq.
REQ-009 The module SHALL have port instrword, output, 32 bits: the instruction currently presented to the datapath.
REQ-010 The module SHALL have port newinstr, output, 1 bit: a one-cycle pulse marking a new instrword.
REQ-011 The module SHALL have ports pc_out (output, 32), halted (output, 1) and busy (output, 1): high in FETCH, ISSUE and WAIT.

Function
REQ-012 States SHALL be IDLE, FETCH, ISSUE, WAIT and HALT, with a registered state register.
REQ-013 IDLE: run=1 -> FETCH; otherwise stay in IDLE.
REQ-014 FETCH (1 cycle): instrword <= imem[pc[7:2]]; if that word == HALT_WORD -> HALT with instrword unchanged; else -> ISSUE.
REQ-015 ISSUE (1 cycle): newinstr=1 for exactly this cycle; gap counter <= ISSUE_GAP-1; -> WAIT.
REQ-016 WAIT: decrement counter each cycle; when counter==0, load the next PC; then run=1 -> FETCH, run=0 -> IDLE.
REQ-017 Next PC when leaving WAIT: opcode (instrword[31:26]) 2 -> {pc4[31:28], instrword[25:0], 2'b00}; opcode 4 with br_zero=1 -> pc4 + (sign-extended instrword[15:0] << 2); otherwise pc4, where pc4 = pc+4.
REQ-018 br_zero SHALL be sampled only on the edge leaving WAIT; its value at all other times SHALL be ignored.
REQ-019 PC arithmetic SHALL be 32-bit modulo 2^32; the memory index SHALL use pc[7:2] only, so addresses wrap modulo IMEM_DEPTH words.
REQ-020 instrword SHALL hold stable from FETCH until the next FETCH; newinstr SHALL never be high in two consecutive cycles.
REQ-021 Issue period SHALL be ISSUE_GAP+2 cycles (10 at default); latency from run sampled high in IDLE to newinstr SHALL be 2 edges.
REQ-022 HALT: halted=1; run=0 -> IDLE with halted cleared; PC SHALL be unchanged while in HALT.
REQ-023 load_en SHALL write imem[load_addr] <= load_data only in IDLE or HALT; writes in other states SHALL be ignored.
REQ-024 run deasserted during FETCH, ISSUE or WAIT SHALL NOT abort the current instruction; the FSM returns to IDLE only at the end of WAIT.
REQ-025 pc_out SHALL equal the PC register at all times.

Reset
REQ-026 reset=0 SHALL asynchronously force state=IDLE, pc=0, instrword=0, newinstr=0, halted=0, busy=0, counter=0.
REQ-027 Instruction memory contents SHALL NOT be cleared by reset.
REQ-028 Reset asserted mid-WAIT SHALL discard the pending PC update and any sampled br_zero.

Verification
REQ-029 Load imem[0..2] with three add (R-type) words, set run=1 -> newinstr pulses 10 cycles apart, pc_out 0,4,8.
REQ-030 beq at pc 0 with imm 3 and br_zero=1 at end of WAIT -> next fetch at pc 16; repeat with br_zero=0 -> next fetch at pc 4.
REQ-031 j with target 5 at pc 8 -> next pc 20; beq imm 16'hFFFF at pc 0 with br_zero=1 -> pc 0.
REQ-032 HALT_WORD at imem[1] -> exactly one newinstr pulse, then halted=1, pc_out stays 4; run=0 -> IDLE with halted=0.
REQ-033 load_en pulsed during WAIT -> imem unchanged; reset pulsed mid-WAIT -> all outputs 0 and a new run restarts at pc 0 with imem intact.
REQ-034 pc at word 63, add instruction -> next fetch reads imem[0], pc_out 256.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: fetches from a small loadable instruction memory,
// issues one instruction every ISSUE_GAP+2 cycles and resolves j/beq for the next PC.
module instr_fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned ISSUE_GAP  = 8,
  parameter logic [31:0] HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        load_en,
  input  logic [5:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic        br_zero,
  output logic [31:0] instrword,
  output logic        newinstr,
  output logic [31:0] pc_out,
  output logic        halted,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [7:0]  gap_cnt;
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] fetch_word;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] pc_next;
  logic [5:0]  opcode;

  assign fetch_word = imem[pc[7:2]];
  assign pc_out     = pc;
  assign opcode     = instrword[31:26];

  always_comb begin
    pc4     = pc + 32'd4;
    br_off  = {{14{instrword[15]}}, instrword[15:0], 2'b00};
    pc_next = pc4;
    if (opcode == 6'd2)
      pc_next = {pc4[31:28], instrword[25:0], 2'b00};
    else if (opcode == 6'd4 && br_zero)
      pc_next = pc4 + br_off;
  end

  // Memory is deliberately outside the reset domain so a reset keeps the program.
  always_ff @(posedge clock) begin
    if (load_en && (state == S_IDLE || state == S_HALT))
      imem[load_addr] <= load_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      instrword <= '0;
      newinstr  <= 1'b0;
      halted    <= 1'b0;
      busy      <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      newinstr <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (fetch_word == HALT_WORD) begin
            state  <= S_HALT;
            halted <= 1'b1;
            busy   <= 1'b0;
          end else begin
            instrword <= fetch_word;
            newinstr  <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          gap_cnt <= 8'(ISSUE_GAP - 1);
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // br_zero only matters on this exit edge; pc_next is ignored otherwise.
          if (gap_cnt == 8'd0) begin
            pc <= pc_next;
            if (run) begin
              state <= S_FETCH;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        S_HALT: begin
          if (!run) begin
            state  <= S_IDLE;
            halted <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
